// File: rtl/lcd12864_bus_sched_if.sv
// Requester handshakes plus the LCD pin bundle of the 12864 write-bus scheduler.
// The scheduler takes the slave side; requesters and observers take the master side.
interface lcd12864_bus_sched_if;
    logic       req0_valid;
    logic       req0_rs;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic       req1_rs;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       init_done;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;
    logic       lcd_rst;
    logic       lcd_psb;

    modport master (
        output req0_valid, req0_rs, req0_data,
        input  req0_ready,
        output req1_valid, req1_rs, req1_data,
        input  req1_ready,
        input  init_done, busy, lcd_rs, lcd_rw, lcd_en, lcd_data, lcd_rst, lcd_psb
    );

    modport slave (
        input  req0_valid, req0_rs, req0_data,
        output req0_ready,
        input  req1_valid, req1_rs, req1_data,
        output req1_ready,
        output init_done, busy, lcd_rs, lcd_rw, lcd_en, lcd_data, lcd_rst, lcd_psb
    );
endinterface

// File: rtl/lcd12864_bus_sched.sv
// ST7920 12864 parallel write-bus owner: reset/power-up/init sequencing, then
// round-robin sharing between two requesters with timed EN strobes and busy waits.
module lcd12864_bus_sched #(
    parameter int unsigned T_RST   = 500,
    parameter int unsigned T_PWRUP = 2000000,
    parameter int unsigned T_SETUP = 4,
    parameter int unsigned T_EN    = 25,
    parameter int unsigned T_HOLD  = 4,
    parameter int unsigned T_CMD   = 3600,
    parameter int unsigned T_CLR   = 80000
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd12864_bus_sched_if.slave bus
);
    typedef enum logic [2:0] {
        S_RST, S_PWRUP, S_LOAD, S_SETUP, S_EN, S_HOLD, S_WAIT, S_IDLE
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_cnt, w_cnt_next;
    logic [1:0]  r_init_idx, w_init_idx_next;
    logic        r_init_done, w_init_done_next;
    logic        r_rr, w_rr_next;
    logic        r_req_rs, w_req_rs_next;
    logic [7:0]  r_req_data, w_req_data_next;
    logic        r_lcd_rs, w_lcd_rs_next;
    logic [7:0]  r_lcd_data, w_lcd_data_next;
    logic        r_lcd_en, w_lcd_en_next;
    logic        r_lcd_rst, w_lcd_rst_next;
    logic        r_busy;
    logic        w_cnt_zero, w_open, w_grant, w_xfer, w_long_wait;
    logic [7:0]  w_init_byte;

    always_comb begin
        case (r_init_idx)
            2'd0:    w_init_byte = 8'h30;
            2'd1:    w_init_byte = 8'h0C;
            2'd2:    w_init_byte = 8'h06;
            default: w_init_byte = 8'h01;
        endcase
    end

    assign w_cnt_zero  = (r_cnt == 32'd0);
    assign w_open      = (r_state == S_IDLE) && r_init_done;
    // A lone valid requester wins outright; the pointer only breaks ties.
    assign w_grant     = (bus.req0_valid && !bus.req1_valid) ? 1'b0 :
                         (bus.req1_valid && !bus.req0_valid) ? 1'b1 : r_rr;
    assign w_xfer      = w_open && (w_grant ? bus.req1_valid : bus.req0_valid);
    // Clear display and return home need the long settle time.
    assign w_long_wait = !r_lcd_rs && (r_lcd_data == 8'h01 || r_lcd_data == 8'h02 ||
                                       r_lcd_data == 8'h03);

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = w_cnt_zero ? 32'd0 : r_cnt - 32'd1;
        w_init_idx_next  = r_init_idx;
        w_init_done_next = r_init_done;
        w_rr_next        = r_rr;
        w_req_rs_next    = r_req_rs;
        w_req_data_next  = r_req_data;
        w_lcd_rs_next    = r_lcd_rs;
        w_lcd_data_next  = r_lcd_data;
        w_lcd_en_next    = r_lcd_en;
        w_lcd_rst_next   = r_lcd_rst;
        case (r_state)
            S_RST: if (w_cnt_zero) begin
                w_lcd_rst_next = 1'b1;
                w_state_next   = S_PWRUP;
                w_cnt_next     = T_PWRUP - 32'd1;
            end
            S_PWRUP: if (w_cnt_zero) begin
                w_init_idx_next = 2'd0;
                w_state_next    = S_LOAD;
            end
            S_LOAD: begin
                w_lcd_rs_next   = r_init_done ? r_req_rs : 1'b0;
                w_lcd_data_next = r_init_done ? r_req_data : w_init_byte;
                w_state_next    = S_SETUP;
                w_cnt_next      = T_SETUP - 32'd1;
            end
            S_SETUP: if (w_cnt_zero) begin
                w_lcd_en_next = 1'b1;
                w_state_next  = S_EN;
                w_cnt_next    = T_EN - 32'd1;
            end
            S_EN: if (w_cnt_zero) begin
                w_lcd_en_next = 1'b0;
                w_state_next  = S_HOLD;
                w_cnt_next    = T_HOLD - 32'd1;
            end
            S_HOLD: if (w_cnt_zero) begin
                w_state_next = S_WAIT;
                w_cnt_next   = w_long_wait ? T_CLR - 32'd1 : T_CMD - 32'd1;
            end
            S_WAIT: if (w_cnt_zero) begin
                if (r_init_done) begin
                    w_state_next = S_IDLE;
                end else if (r_init_idx == 2'd3) begin
                    w_init_done_next = 1'b1;
                    w_state_next     = S_IDLE;
                end else begin
                    w_init_idx_next = r_init_idx + 2'd1;
                    w_state_next    = S_LOAD;
                end
            end
            S_IDLE: if (w_xfer) begin
                w_req_rs_next   = w_grant ? bus.req1_rs : bus.req0_rs;
                w_req_data_next = w_grant ? bus.req1_data : bus.req0_data;
                w_rr_next       = !w_grant;
                w_state_next    = S_LOAD;
            end
            default: w_state_next = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RST;
            r_cnt       <= T_RST - 32'd1;
            r_init_idx  <= 2'd0;
            r_init_done <= 1'b0;
            r_rr        <= 1'b0;
            r_req_rs    <= 1'b0;
            r_req_data  <= 8'h00;
            r_lcd_rs    <= 1'b0;
            r_lcd_data  <= 8'h00;
            r_lcd_en    <= 1'b0;
            r_lcd_rst   <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_init_idx  <= w_init_idx_next;
            r_init_done <= w_init_done_next;
            r_rr        <= w_rr_next;
            r_req_rs    <= w_req_rs_next;
            r_req_data  <= w_req_data_next;
            r_lcd_rs    <= w_lcd_rs_next;
            r_lcd_data  <= w_lcd_data_next;
            r_lcd_en    <= w_lcd_en_next;
            r_lcd_rst   <= w_lcd_rst_next;
            r_busy      <= (w_state_next != S_IDLE);
        end
    end

    assign bus.req0_ready = w_open && !w_grant;
    assign bus.req1_ready = w_open && w_grant;
    assign bus.init_done  = r_init_done;
    assign bus.busy       = r_busy;
    assign bus.lcd_rs     = r_lcd_rs;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_en     = r_lcd_en;
    assign bus.lcd_data   = r_lcd_data;
    assign bus.lcd_rst    = r_lcd_rst;
    assign bus.lcd_psb    = 1'b1;
endmodule

// File: tb/tb_lcd12864_bus_sched.sv
// Bench for lcd12864_bus_sched: an event-timeline model of every write predicts the
// LCD pins, busy/init_done and both readies each cycle; directed tests pin the model.
module tb_lcd12864_bus_sched;
    localparam int P_RST = 4, P_PWRUP = 10, P_SETUP = 2, P_EN = 3, P_HOLD = 2;
    localparam int P_CMD = 5, P_CLR = 20;

    logic clk = 1'b0;
    logic rst_n;
    lcd12864_bus_sched_if bus();

    lcd12864_bus_sched #(
        .T_RST(P_RST), .T_PWRUP(P_PWRUP), .T_SETUP(P_SETUP), .T_EN(P_EN),
        .T_HOLD(P_HOLD), .T_CMD(P_CMD), .T_CLR(P_CLR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int c = 0;

    // model: one write = LOAD cycle m_L, pins show the new byte from m_L+1, next LOAD/idle at m_end
    logic [7:0] init_tab [4] = '{8'h30, 8'h0C, 8'h06, 8'h01};
    int         m_L, m_end, m_idx;
    bit         m_done, m_rr, m_xfer0, m_xfer1;
    logic       m_rs, m_prs;
    logic [7:0] m_d, m_pd;

    // observations of the DUT, used by the literal checks
    int  obs_rises, obs_rise_c, obs_idle_c, obs_xfer_c, obs_done_c, obs_init_rises;
    bit  prev_en, prev_busy, prev_done;
    int  obs_grants[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", nm, c, act, exp);
        end
    endtask

    function automatic int wait_of(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'h01 && d <= 8'h03) ? P_CLR : P_CMD;
    endfunction

    task automatic start_write(input int L, input logic rs, input logic [7:0] d);
        m_prs = m_rs;
        m_pd  = m_d;
        m_rs  = rs;
        m_d   = d;
        m_L   = L;
        m_end = L + 1 + P_SETUP + P_EN + P_HOLD + wait_of(rs, d);
    endtask

    // compare process
    always begin
        bit   e_idle, g, v0, v1, e_en;
        logic e_rs;
        logic [7:0] e_d;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            chk("rst_en", int'(bus.lcd_en), 0);
            chk("rst_lcd_rst", int'(bus.lcd_rst), 0);
            chk("rst_busy", int'(bus.busy), 1);
            chk("rst_done", int'(bus.init_done), 0);
            chk("rst_bus", int'({bus.lcd_rs, bus.lcd_data}), 0);
            chk("rst_ready", int'({bus.req1_ready, bus.req0_ready}), 0);
            c = 0; m_idx = 0; m_done = 0; m_rr = 0; m_rs = 0; m_d = 8'h00;
            start_write(P_RST + P_PWRUP, 1'b0, 8'h30);
            m_xfer0 = 0; m_xfer1 = 0;
            obs_rises = 0; prev_en = 0; prev_busy = 1; prev_done = 0;
        end else begin
            if (!m_done && c == m_end) begin
                if (m_idx == 3) m_done = 1'b1;
                else begin
                    m_idx++;
                    start_write(c, 1'b0, init_tab[m_idx]);
                end
            end
            e_idle = m_done && (c >= m_end);
            v0 = bus.req0_valid;
            v1 = bus.req1_valid;
            g  = (v0 && !v1) ? 1'b0 : (v1 && !v0) ? 1'b1 : m_rr;
            e_en = (c >= m_L + 1 + P_SETUP) && (c <= m_L + P_SETUP + P_EN);
            e_rs = (c >= m_L + 1) ? m_rs : m_prs;
            e_d  = (c >= m_L + 1) ? m_d : m_pd;
            chk("ready0", int'(bus.req0_ready), int'(e_idle && !g));
            chk("ready1", int'(bus.req1_ready), int'(e_idle && g));
            chk("lcd_en", int'(bus.lcd_en), int'(e_en));
            chk("lcd_rs", int'(bus.lcd_rs), int'(e_rs));
            chk("lcd_data", int'(bus.lcd_data), int'(e_d));
            chk("lcd_rst", int'(bus.lcd_rst), int'(c >= P_RST));
            chk("busy", int'(bus.busy), int'(!e_idle));
            chk("init_done", int'(bus.init_done), int'(m_done));
            chk("rw_psb", int'({bus.lcd_rw, bus.lcd_psb}), 1);

            if (bus.lcd_en && !prev_en) begin obs_rises++; obs_rise_c = c; end
            if (!bus.busy && prev_busy) obs_idle_c = c;
            if (bus.init_done && !prev_done) begin obs_done_c = c; obs_init_rises = obs_rises; end
            if (bus.req0_valid && bus.req0_ready) begin
                obs_xfer_c = c; obs_grants.push_back(0);
                $display("cycle %0d: req0 rs=%0b data=0x%02h", c, bus.req0_rs, bus.req0_data);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                obs_xfer_c = c; obs_grants.push_back(1);
                $display("cycle %0d: req1 rs=%0b data=0x%02h", c, bus.req1_rs, bus.req1_data);
            end
            prev_en = bus.lcd_en; prev_busy = bus.busy; prev_done = bus.init_done;

            m_xfer0 = e_idle && !g && v0;
            m_xfer1 = e_idle && g && v1;
            if (m_xfer0 || m_xfer1) begin
                start_write(c + 1, g ? bus.req1_rs : bus.req0_rs, g ? bus.req1_data : bus.req0_data);
                m_rr = !g;
            end
            c++;
        end
    end

    task automatic drive(input int n, input bit v, input logic rs, input logic [7:0] d);
        if (n == 0) begin bus.req0_valid = v; bus.req0_rs = rs; bus.req0_data = d; end
        else begin bus.req1_valid = v; bus.req1_rs = rs; bus.req1_data = d; end
    endtask

    task automatic send(input int n, input logic rs, input logic [7:0] d);
        bit got = 0;
        @(negedge clk); #1;
        drive(n, 1'b1, rs, d);
        for (int k = 0; k < 200 && !got; k++) begin
            #2;
            got = (n == 0) ? m_xfer0 : m_xfer1;
            if (!got) begin @(negedge clk); #1; end
        end
        chk("send_accept", int'(got), 1);
        @(negedge clk); #1;
        drive(n, 1'b0, rs, d);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin @(negedge clk); #3; ok = !bus.busy; end
        chk("idle_wait", int'(ok), 1);
    endtask

    task automatic check_init();
        bit ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin @(negedge clk); #3; ok = bus.init_done; end
        chk("init_wait", int'(ok), 1);
        chk("init_done_cyc", obs_done_c, 81);
        chk("init_pulses", obs_init_rises, 4);
    endtask

    function automatic logic [7:0] rnd_byte();
        if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 4));
        return 8'($urandom);
    endfunction

    initial begin
        int start, total, r0;
        bit ok;
        logic [7:0] n0, n1;
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        check_init();

        // single data write: EN rises 4 cycles after transfer, idle again 14 cycles after it
        send(0, 1'b1, 8'h57);
        wait_idle();
        chk("t2_en_lat", obs_rise_c - obs_xfer_c, 4);
        chk("t2_idle_lat", obs_idle_c - obs_xfer_c, 14);

        send(1, 1'b0, 8'h01);
        wait_idle();
        chk("t4_clr_lat", obs_idle_c - obs_xfer_c, 29);
        send(1, 1'b1, 8'h01);
        wait_idle();
        chk("t4_data_lat", obs_idle_c - obs_xfer_c, 14);

        // both requesters continuously valid: grants alternate starting with req0
        start = obs_grants.size(); total = 0; n0 = 8'hA0; n1 = 8'hB0;
        @(negedge clk); #1;
        drive(0, 1'b1, 1'b1, n0);
        drive(1, 1'b1, 1'b1, n1);
        for (int k = 0; k < 400 && total < 4; k++) begin
            #2;
            if (m_xfer0 || m_xfer1) total++;
            @(negedge clk); #1;
            if (m_xfer0) begin n0++; bus.req0_data = n0; end
            if (m_xfer1) begin n1++; bus.req1_data = n1; end
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("t3_count", obs_grants.size() - start, 4);
        if (obs_grants.size() >= start + 4)
            for (int i = 0; i < 4; i++) chk("t3_grant", obs_grants[start + i], i % 2);
        wait_idle();

        // valid pulse while busy must not transfer nor move the pointer
        r0 = obs_rises;
        send(0, 1'b1, 8'h33);
        @(negedge clk); #1; drive(0, 1'b1, 1'b1, 8'hEE);
        @(negedge clk); #1; drive(0, 1'b0, 1'b1, 8'hEE);
        wait_idle();
        chk("t6_one_write", obs_rises - r0, 1);
        start = obs_grants.size(); ok = 0;
        @(negedge clk); #1;
        drive(0, 1'b1, 1'b1, 8'h44);
        drive(1, 1'b1, 1'b1, 8'h55);
        for (int k = 0; k < 100 && !ok; k++) begin
            #2;
            ok = m_xfer0 || m_xfer1;
            if (!ok) begin @(negedge clk); #1; end
        end
        @(negedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("t6_xfer", int'(ok), 1);
        if (obs_grants.size() > start) chk("t6_rr_kept", obs_grants[start], 1);
        wait_idle();

        // reset in the middle of an EN strobe, with a request pending across it
        send(0, 1'b1, 8'hC5);
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin @(negedge clk); #3; ok = bus.lcd_en; end
        chk("t5_en_seen", int'(ok), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_en_drop", int'(bus.lcd_en), 0);
        chk("t5_rst_low", int'(bus.lcd_rst), 0);
        drive(1, 1'b1, 1'b1, 8'h99);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        check_init();
        ok = m_xfer1;
        for (int k = 0; k < 50 && !ok; k++) begin @(negedge clk); #3; ok = m_xfer1; end
        chk("t5_pending_xfer", int'(ok), 1);
        @(negedge clk); #1; bus.req1_valid = 1'b0;
        wait_idle();

        // randomized traffic on both requesters
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk); #1;
            if (bus.req0_valid) begin
                if (m_xfer0 || $urandom_range(0, 19) == 0) bus.req0_valid = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                drive(0, 1'b1, 1'($urandom_range(0, 1)), rnd_byte());
            end
            if (bus.req1_valid) begin
                if (m_xfer1 || $urandom_range(0, 19) == 0) bus.req1_valid = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                drive(1, 1'b1, 1'($urandom_range(0, 1)), rnd_byte());
            end
        end
        @(negedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected $finish before time 1000000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lcd12864_bus_sched.md
Name: lcd12864_bus_sched

Overview:
Owns the ST7920-class 12864 LCD 8-bit parallel write bus. After reset it drives the hardware reset pulse, waits for power-up, and issues the fixed init sequence 0x30, 0x0C, 0x06, 0x01. It then shares the bus between two requesters with round-robin arbitration. Each accepted byte becomes one timed EN strobe followed by a command-dependent busy wait, so clients never need to poll the busy flag.

Parameters:
T_RST, 500, cycles lcd_rst is held low after reset.
T_PWRUP, 2000000, cycles waited after lcd_rst rises, before the first init write (40 ms at 50 MHz).
T_SETUP, 4, cycles lcd_rs/lcd_data are stable before lcd_en rises.
T_EN, 25, cycles lcd_en is high.
T_HOLD, 4, cycles lcd_rs/lcd_data are held after lcd_en falls.
T_CMD, 3600, post-write wait for data bytes and ordinary commands (72 us).
T_CLR, 80000, post-write wait for commands 0x01 and 0x02/0x03 (1.6 ms).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a byte
req0_rs  in  1  requester 0 register select (0 = command, 1 = data)
req0_data  in  8  requester 0 byte
req0_ready  out  1  requester 0 byte accepted this cycle when valid&ready
req1_valid / req1_rs / req1_data / req1_ready  same as requester 0
init_done  out  1  init sequence complete; stays high until reset
busy  out  1  write engine not in IDLE
lcd_rs  out  1  LCD RS
lcd_rw  out  1  LCD RW, constant 0
lcd_en  out  1  LCD E strobe
lcd_data  out  8  LCD DB7..DB0
lcd_rst  out  1  LCD reset, active low
lcd_psb  out  1  parallel mode select, constant 1

Behaviour:
- Reset values (async, immediate): lcd_en=0, lcd_rs=0, lcd_data=0x00, lcd_rw=0, lcd_psb=1, lcd_rst=0, init_done=0, busy=1, rr pointer=0 (req0 preferred), state=RST. All LCD outputs except ready are registered.
- States:
  - RST: lcd_rst=0 for T_RST cycles, then lcd_rst=1 → PWRUP.
  - PWRUP: waits T_PWRUP cycles → LOAD with init index 0.
  - LOAD: latches the byte (init ROM entry while !init_done, otherwise the granted request) into lcd_rs/lcd_data → SETUP.
  - SETUP: T_SETUP cycles → EN.
  - EN: lcd_en=1 for T_EN cycles → HOLD.
  - HOLD: lcd_en=0, bus held for T_HOLD cycles → WAIT.
  - WAIT: T_CLR cycles if the latched byte was rs=0 and data in {0x01,0x02,0x03}, otherwise T_CMD cycles. Exit goes to LOAD for the next init entry; after init entry 3 it sets init_done=1 and goes to IDLE; when init_done is already 1 it goes to IDLE.
  - IDLE: busy=0.
- Handshake:
  - reqN_ready is combinational: state==IDLE && init_done && grant==N. Never asserted otherwise.
  - grant: only one valid requester → that one. Both valid → the one the rr pointer selects.
  - On transfer (valid&ready) the engine captures rs/data and goes IDLE→LOAD; the rr pointer flips to the non-granted requester. Non-transfer cycles leave the pointer unchanged.
  - Requesters must hold valid/rs/data stable until ready. A dropped valid is legal: no transfer.
- Latency: transfer at cycle t → lcd_en rises at t+1+T_SETUP+1 (LOAD plus SETUP). Next ready no earlier than t+2+T_SETUP+T_EN+T_HOLD+wait.
- At most one transfer per write cycle. Both ready signals are never high together.
- lcd_data/lcd_rs keep the last value after HOLD (no return to 0) until the next LOAD.
- Counters are 32-bit, load value−1, count down to 0. Any parameter value of 1 gives exactly 1 cycle. Parameter value 0 is illegal.
- rst_n low mid-strobe: lcd_en drops at once and the full RST/PWRUP/init sequence is repeated. Requests pending across reset are not accepted until init_done rises again.

Test Plan:
1. Sim params T_RST=4, T_PWRUP=10, T_SETUP=2, T_EN=3, T_HOLD=2, T_CMD=5, T_CLR=20; release rst_n → lcd_rst low 4 cycles. Exactly four EN pulses (each 3 cycles high) carrying rs=0 and 0x30, 0x0C, 0x06, 0x01. 20-cycle gap after 0x01, then init_done=1. No ready before init_done.
2. After init, req0 sends rs=1 0x57 → req0_ready one cycle. lcd_en rises 4 cycles after the transfer with lcd_rs=1, lcd_data=0x57 stable from 2 cycles before the rise to 2 cycles after the fall. Next ready follows after the 5-cycle T_CMD wait.
3. req0 and req1 both valid continuously with distinct bytes → grants alternate 0,1,0,1. Never both ready in one cycle. Byte order on lcd_data matches the grants.
4. req1 sends rs=0 0x01 → post-write gap is 20 cycles; rs=1 0x01 → gap is 5 cycles.
5. Assert rst_n low during EN of a data write → lcd_en=0 and lcd_rst=0 in the same cycle. After release, the full init sequence repeats and init_done re-asserts.
6. req0_valid pulses high for one cycle while the engine is busy → no transfer and no EN pulse; the rr pointer is unchanged.
